// File: rtl/mm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_ctrl_pkg
// Description : Shared constants for the matrix-multiply control slice:
//               default tile/timeout limits and the accumulate sequencer
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mm_ctrl_pkg;

    // Default limits for one block product
    localparam int c_MAX_TILES_DEF      = 16;
    localparam int c_TIMEOUT_CYCLES_DEF = 1024;

    // Sequencer state encoding
    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE   = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_CLEAR  = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_LAUNCH = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT   = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_ACCUM  = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_DRAIN  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/pass_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : pass_watchdog
// Description : Saturating cycle counter that bounds one systolic pass.
// Revision    : 1.0 - initial release
//
// Ports
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-high reset (already release-synchronised)
//   clear   in   zero the count
//   enable  in   count this cycle
//   expired out  this enabled cycle brings the count to TIMEOUT_CYCLES
// ============================================================================
module pass_watchdog
    import mm_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0] r_count;

    // Count holds at the limit instead of wrapping back to zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_LIMIT)) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    // Flag the enabled cycle that completes the limit so the FSM leaves WAIT
    // after exactly TIMEOUT_CYCLES waiting cycles.
    assign expired = enable && (r_count >= (c_LIMIT - c_CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/accum_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : accum_sequencer
// Description : Sequences K-tile passes of a systolic array into an
//               accumulator: clear, then per tile launch/wait/accumulate,
//               then hold the result until downstream accepts it.
// Revision    : 1.0 - initial release
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   start       in   one-cycle request to begin a block product
//   num_tiles   in   K-tile count, sampled when start is accepted
//   sys_done    in   systolic pass-complete pulse
//   out_ready   in   downstream accepts the result
//   sys_start   out  one-cycle pulse launching a systolic pass
//   tile_idx    out  current tile index for operand fetch
//   acc_clear   out  one-cycle pulse zeroing the accumulator
//   acc_en      out  one-cycle pulse adding the pass result
//   out_valid   out  accumulated result ready
//   busy        out  high in every state except IDLE
//   timeout_err out  sticky watchdog error
// ============================================================================
module accum_sequencer
    import mm_ctrl_pkg::*;
#(
    parameter int MAX_TILES      = c_MAX_TILES_DEF,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] num_tiles,
    input  logic       sys_done,
    input  logic       out_ready,
    output logic       sys_start,
    output logic [3:0] tile_idx,
    output logic       acc_clear,
    output logic       acc_en,
    output logic       out_valid,
    output logic       busy,
    output logic       timeout_err
);

    localparam int c_CNT_W = $clog2(MAX_TILES + 1);

    logic [1:0]           r_rst_sync;
    logic                 w_rst;
    logic [c_STATE_W-1:0] r_state;
    logic [3:0]           r_tile_idx;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_sys_start;
    logic                 r_acc_clear;
    logic                 r_acc_en;
    logic                 r_out_valid;
    logic                 r_busy;
    logic                 r_timeout_err;
    logic [c_CNT_W-1:0]   w_req_count;
    logic                 w_last;
    logic                 w_wd_clear;
    logic                 w_wd_enable;
    logic                 w_wd_expired;

    // Reset asserts immediately but releases only after two clock edges
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

    // Requested tile count clamped to the supported maximum
    assign w_req_count = (int'(num_tiles) > MAX_TILES) ? c_CNT_W'(MAX_TILES)
                                                       : c_CNT_W'(num_tiles);

    assign w_last      = (c_CNT_W'(r_tile_idx) == (r_count - c_CNT_W'(1)));
    assign w_wd_clear  = (r_state == c_ST_LAUNCH);
    assign w_wd_enable = (r_state == c_ST_WAIT) && !sys_done;

    pass_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset   (w_rst),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expired (w_wd_expired)
    );

    // Outputs are registered alongside the state: each pulse is set on the
    // edge that enters its state and dropped on the following edge.
    always_ff @(posedge clock or posedge w_rst) begin
        if (w_rst) begin
            r_state       <= c_ST_IDLE;
            r_tile_idx    <= '0;
            r_count       <= '0;
            r_sys_start   <= 1'b0;
            r_acc_clear   <= 1'b0;
            r_acc_en      <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_sys_start <= 1'b0;
            r_acc_clear <= 1'b0;
            r_acc_en    <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start && (num_tiles != 5'd0)) begin
                        r_count       <= w_req_count;
                        r_tile_idx    <= '0;
                        r_timeout_err <= 1'b0;
                        r_acc_clear   <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= c_ST_CLEAR;
                    end
                end
                c_ST_CLEAR: begin
                    r_tile_idx  <= '0;
                    r_sys_start <= 1'b1;
                    r_state     <= c_ST_LAUNCH;
                end
                c_ST_LAUNCH: begin
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (sys_done) begin
                        r_acc_en <= 1'b1;
                        r_state  <= c_ST_ACCUM;
                    end else if (w_wd_expired) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= c_ST_IDLE;
                    end
                end
                c_ST_ACCUM: begin
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_DRAIN;
                    end else begin
                        r_tile_idx  <= r_tile_idx + 4'd1;
                        r_sys_start <= 1'b1;
                        r_state     <= c_ST_LAUNCH;
                    end
                end
                c_ST_DRAIN: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign sys_start   = r_sys_start;
    assign tile_idx    = r_tile_idx;
    assign acc_clear   = r_acc_clear;
    assign acc_en      = r_acc_en;
    assign out_valid   = r_out_valid;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
